// File: rtl/mini_src_pkg.sv
// Shared opcode, ALU-code and state definitions for the mini SRC control unit.
package mini_src_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_SUB  = 5'b00100;
  localparam logic [4:0] ALU_AND  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;

  typedef enum logic [2:0] {
    S_RST,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_HALT
  } state_t;

  typedef struct packed {
    logic       is_alu;
    logic       is_imm;
    logic       is_nop;
    logic       is_halt;
    logic       is_illegal;
    logic [4:0] alu_code;
  } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode classifier: instruction class flags and the ALU operation to use.
module ctrl_decode
  import mini_src_pkg::*;
(
  input  logic [4:0] op_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '0;
    dec_o.alu_code = ALU_NONE;
    unique case (op_i)
      OP_ADD: begin
        dec_o.is_alu = 1'b1;
        dec_o.alu_code = ALU_ADD;
      end
      OP_SUB: begin
        dec_o.is_alu = 1'b1;
        dec_o.alu_code = ALU_SUB;
      end
      OP_AND: begin
        dec_o.is_alu = 1'b1;
        dec_o.alu_code = ALU_AND;
      end
      OP_OR: begin
        dec_o.is_alu = 1'b1;
        dec_o.alu_code = ALU_OR;
      end
      OP_ADDI: begin
        dec_o.is_alu = 1'b1;
        dec_o.is_imm = 1'b1;
        dec_o.alu_code = ALU_ADD;
      end
      OP_ANDI: begin
        dec_o.is_alu = 1'b1;
        dec_o.is_imm = 1'b1;
        dec_o.alu_code = ALU_AND;
      end
      OP_ORI: begin
        dec_o.is_alu = 1'b1;
        dec_o.is_imm = 1'b1;
        dec_o.alu_code = ALU_OR;
      end
      OP_NOP:  dec_o.is_nop = 1'b1;
      OP_HALT: dec_o.is_halt = 1'b1;
      default: dec_o.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T0..T5 control sequencer for the mini SRC datapath.
// Define MEM_WAIT_EN to stretch T1 until mem_ready is high.
module control_sequencer
  import mini_src_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        Pout,
  output logic        Pen,
  output logic        IncPC,
  output logic        MARen,
  output logic        Read,
  output logic        MDRen,
  output logic        MDROut,
  output logic        IRen,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rout,
  output logic        Rin,
  output logic        Yen,
  output logic        Cout,
  output logic        Zen,
  output logic        ZLOout,
  output logic        run,
  output logic        illegal,
  output logic [4:0]  alu_control
);

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  dec_t   dec;

  logic [26:0] ir_unused;
  assign ir_unused = ir[26:0];

`ifndef MEM_WAIT_EN
  logic mem_ready_unused;
  assign mem_ready_unused = mem_ready;
`endif

  ctrl_decode u_dec (
    .op_i  (ir[31:27]),
    .dec_o (dec)
  );

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q   <= S_RST;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    Pout        = 1'b0;
    Pen         = 1'b0;
    IncPC       = 1'b0;
    MARen       = 1'b0;
    Read        = 1'b0;
    MDRen       = 1'b0;
    MDROut      = 1'b0;
    IRen        = 1'b0;
    Gra         = 1'b0;
    Grb         = 1'b0;
    Grc         = 1'b0;
    Rout        = 1'b0;
    Rin         = 1'b0;
    Yen         = 1'b0;
    Cout        = 1'b0;
    Zen         = 1'b0;
    ZLOout      = 1'b0;
    run         = 1'b0;
    alu_control = ALU_NONE;
    unique case (state_q)
      S_RST: state_d = S_T0;
      S_T0: begin
        run         = 1'b1;
        Pout        = 1'b1;
        MARen       = 1'b1;
        IncPC       = 1'b1;
        Zen         = 1'b1;
        alu_control = ALU_ADD;
        state_d     = S_T1;
      end
      S_T1: begin
        run    = 1'b1;
        ZLOout = 1'b1;
        Pen    = 1'b1;
        Read   = 1'b1;
        MDRen  = 1'b1;
`ifdef MEM_WAIT_EN
        state_d = mem_ready ? S_T2 : S_T1;
`else
        state_d = S_T2;
`endif
      end
      S_T2: begin
        run     = 1'b1;
        MDROut  = 1'b1;
        IRen    = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        run = 1'b1;
        if (dec.is_alu) begin
          Grb     = 1'b1;
          Rout    = 1'b1;
          Yen     = 1'b1;
          state_d = S_T4;
        end else if (dec.is_nop) begin
          state_d = S_T0;
        end else begin
          // Illegal opcodes park in HALT with the sticky flag set.
          illegal_d = illegal_q | dec.is_illegal;
          state_d   = S_HALT;
        end
      end
      S_T4: begin
        run         = 1'b1;
        Zen         = 1'b1;
        alu_control = dec.alu_code;
        Cout        = dec.is_imm;
        Grc         = ~dec.is_imm;
        Rout        = ~dec.is_imm;
        state_d     = S_T5;
      end
      S_T5: begin
        run     = 1'b1;
        ZLOout  = 1'b1;
        Gra     = 1'b1;
        Rin     = 1'b1;
        state_d = S_T0;
      end
      default: state_d = S_HALT;
    endcase
    illegal = illegal_q |
              ((state_q == S_T3) & dec.is_illegal);
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Random and directed stimulus checked cycle by cycle against a phase model.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ir;
  logic        mem_ready;
  logic Pout, Pen, IncPC, MARen, Read, MDRen, MDROut, IRen;
  logic Gra, Grb, Grc, Rout, Rin, Yen, Cout, Zen, ZLOout;
  logic run, illegal;
  logic [4:0] alu_control;

  int errors = 0;
  int checks = 0;

  // Model state: -1 reset, 0..5 = T0..T5, 6 = halted.
  int mph;
  bit mill;
  int halt_cnt;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready),
    .Pout(Pout), .Pen(Pen), .IncPC(IncPC), .MARen(MARen),
    .Read(Read), .MDRen(MDRen), .MDROut(MDROut), .IRen(IRen),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rout(Rout), .Rin(Rin),
    .Yen(Yen), .Cout(Cout), .Zen(Zen), .ZLOout(ZLOout),
    .run(run), .illegal(illegal), .alu_control(alu_control)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit op_alu(input logic [4:0] op);
    return op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd13, 5'd14};
  endfunction

  function automatic bit op_bad(input logic [4:0] op);
    return !op_alu(op) && op != 5'b11010 && op != 5'b11011;
  endfunction

  function automatic logic [4:0] imm_alu(input logic [4:0] op);
    case (op)
      5'd12:   return 5'd3;
      5'd13:   return 5'd5;
      default: return 5'd6;
    endcase
  endfunction

  function automatic logic [23:0] expect_out(input int ph,
                                             input logic [4:0] op,
                                             input bit ill);
    bit po, pe, inc, mar, rd, mdr, mdo, ire, ga, gb, gc;
    bit ro, ri, ye, co, ze, zl, rn, il;
    logic [4:0] alu;
    {po, pe, inc, mar, rd, mdr, mdo, ire, ga, gb, gc} = '0;
    {ro, ri, ye, co, ze, zl, rn, il} = '0;
    alu = 5'd0;
    rn = (ph >= 0 && ph <= 5);
    il = ill;
    case (ph)
      0: begin po = 1; mar = 1; inc = 1; ze = 1; alu = 5'd3; end
      1: begin zl = 1; pe = 1; rd = 1; mdr = 1; end
      2: begin mdo = 1; ire = 1; end
      3: begin
        if (op_alu(op)) begin gb = 1; ro = 1; ye = 1; end
        if (op_bad(op)) il = 1;
      end
      4: begin
        ze = 1;
        if (op >= 5'd12) begin co = 1; alu = imm_alu(op); end
        else begin gc = 1; ro = 1; alu = op; end
      end
      5: begin zl = 1; ga = 1; ri = 1; end
      default: ;
    endcase
    return {po, pe, inc, mar, rd, mdr, mdo, ire, ga, gb, gc,
            ro, ri, ye, co, ze, zl, rn, il, alu};
  endfunction

  // One clock: apply inputs, compare outputs, advance the model.
  task automatic step(input bit c, input logic [4:0] op, input bit mr);
    logic [23:0] got;
    @(negedge clk);
    clr = c;
    ir = {op, 27'($urandom)};
    mem_ready = mr;
    #1;
    got = {Pout, Pen, IncPC, MARen, Read, MDRen, MDROut, IRen,
           Gra, Grb, Grc, Rout, Rin, Yen, Cout, Zen, ZLOout,
           run, illegal, alu_control};
    check($sformatf("outs ph=%0d op=%b", mph, op),
          32'(got), 32'(expect_out(mph, op, mill)));
    if (!c) begin
      mph = -1;
      mill = 0;
    end else begin
      case (mph)
        -1: mph = 0;
        1: begin
`ifdef MEM_WAIT_EN
          if (mr) mph = 2;
`else
          mph = 2;
`endif
        end
        3: begin
          if (op_alu(op)) mph = 4;
          else if (op == 5'b11010) mph = 0;
          else begin
            mph = 6;
            if (op_bad(op)) mill = 1;
          end
        end
        5: mph = 0;
        6: mph = 6;
        default: mph = mph + 1;
      endcase
    end
  endtask

  task automatic steps(input int n, input logic [4:0] op, input bit mr);
    for (int k = 0; k < n; k++) step(1'b1, op, mr);
  endtask

  logic [4:0] cur_op;
  bit         c_r;
  bit         m_r;
  int         pick;

  initial begin
    clr = 1'b0;
    ir = '0;
    mem_ready = 1'b1;
    mph = -1;
    mill = 0;
    @(posedge clk);
    step(1'b0, 5'd0, 1'b1);
    steps(7, 5'b01100, 1'b1);
    steps(6, 5'b00100, 1'b1);
    steps(8, 5'b11010, 1'b1);
    steps(14, 5'b11011, 1'b1);
    step(1'b0, 5'd0, 1'b1);
    steps(16, 5'b11111, 1'b1);
    step(1'b0, 5'd0, 1'b1);
    steps(5, 5'b00011, 1'b1);
    step(1'b0, 5'b00011, 1'b1);
    steps(3, 5'b00110, 1'b1);
    steps(2, 5'b00110, 1'b0);
    steps(2, 5'b00110, 1'b0);
    steps(8, 5'b00110, 1'b1);
    cur_op = 5'b00011;
    halt_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if (mph == 0 || mph == -1 || mph == 6) begin
        pick = int'($urandom_range(0, 15));
        case (pick)
          0, 1, 2, 3, 4, 5, 6: begin
            case (pick)
              0: cur_op = 5'b00011;
              1: cur_op = 5'b00100;
              2: cur_op = 5'b00101;
              3: cur_op = 5'b00110;
              4: cur_op = 5'b01100;
              5: cur_op = 5'b01101;
              default: cur_op = 5'b01110;
            endcase
          end
          7, 8, 9, 10: cur_op = 5'b11010;
          11, 12: cur_op = 5'b11011;
          default: cur_op = 5'($urandom);
        endcase
      end
      halt_cnt = (mph == 6) ? halt_cnt + 1 : 0;
      c_r = !(halt_cnt > 10 || $urandom_range(0, 59) == 0);
      m_r = ($urandom_range(0, 2) != 0);
      step(c_r, cur_op, m_r);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have these ports: clk in 1, single clock, all state updates on rising edge.
REQ-002 clr in 1, synchronous active-low reset.
REQ-003 ir in 32, instruction register contents; opcode is ir[31:27].
REQ-004 mem_ready in 1, memory read-data-valid.
REQ-005 The block SHALL drive 1-bit outputs Pout, Pen, IncPC, MARen, Read, MDRen, MDROut, IRen, Gra, Grb, Grc, Rout, Rin, Yen, Cout, Zen, ZLOout, run, illegal.
REQ-006 The block SHALL drive alu_control out 5, the ALU operation select.

Function
REQ-007 Opcodes SHALL be add 00011, sub 00100, and 00101, or 00110, addi 01100, andi 01101, ori 01110, nop 11010, halt 11011; all others are illegal.
REQ-008 ALU codes SHALL be ADD 00011, SUB 00100, AND 00101, OR 00110, NONE 00000.
REQ-009 States SHALL be RST, T0, T1, T2, T3, T4, T5, HALT, held in one registered state variable.
REQ-010 Outputs SHALL be a combinational function of state and ir only; every output not listed for a state is 0.
REQ-011 T0: Pout, MARen, IncPC, Zen, alu_control=ADD; next T1.
REQ-012 T1: ZLOout, Pen, Read, MDRen; next T2.
REQ-013 T2: MDROut, IRen; next T3.
REQ-014 T3 decodes ir: ALU ops assert Grb, Rout, Yen and go to T4; nop asserts nothing and goes to T0; halt goes to HALT; an illegal opcode sets illegal and goes to HALT.
REQ-015 T4 register form: Grc, Rout, Zen, alu_control=op code. Immediate form: Cout, Zen, alu_control=ADD/AND/OR for addi/andi/ori. Next state: T5.
REQ-016 T5: ZLOout, Gra, Rin; next T0.
REQ-017 Latency SHALL be 6 cycles per ALU instruction and 4 per nop, T0 to T0, with no memory wait.
REQ-018 HALT: all strobes 0, run=0; it is exited only by reset.
REQ-019 run SHALL be 1 in T0..T5 and 0 in RST and HALT.
REQ-020 illegal SHALL be sticky until reset.

Reset
REQ-021 clr=0 at a rising edge SHALL force RST from any state, including mid-instruction, and clear illegal.
REQ-022 In RST all outputs SHALL be 0, including alu_control=00000 and run=0.
REQ-023 RST with clr=1 SHALL go to T0 on the next edge.

Configuration
REQ-024 Macro MEM_WAIT_EN defined: T1 SHALL hold while mem_ready=0, keeping the T1 outputs asserted, and advance to T2 on the edge where mem_ready=1.
REQ-025 MEM_WAIT_EN undefined: mem_ready SHALL be ignored and T1 always lasts one cycle.

Structure
REQ-026 Package mini_src_pkg SHALL hold the opcode constants, ALU codes and the state enum.
REQ-027 Sub-module ctrl_decode SHALL map opcode to {is_alu, is_imm, is_nop, is_halt, is_illegal, alu_code}.

Verification
REQ-028 Reset then ir=addi (0x6000_0000 | fields): states T0..T5 in order; T4 Cout=1 with alu_control=00011; T5 Gra=Rin=ZLOout=1; back to T0 at cycle 7.
REQ-029 ir=sub register form: T4 Grc=Rout=Zen=1, Cout=0, alu_control=00100.
REQ-030 ir=nop (opcode 11010): T0 recurs 4 cycles after the previous T0, with no Yen or Rin pulses.
REQ-031 ir=halt, and separately opcode 11111: HALT reached with run=0; illegal=1 only for 11111; both held for 10 cycles until clr=0.
REQ-032 clr=0 asserted during T4: next edge RST with all outputs 0; after clr=1, T0 follows one cycle later.
REQ-033 With MEM_WAIT_EN and mem_ready low for 3 cycles: T1 lasts 4 cycles with Read=MDRen=1 throughout, then T2 follows.
